// File: rtl/dac_bus_receiver.sv
// Receiver for the quad 8-bit parallel DAC write bus: synchronizes the bus, decodes writes into
// input registers, and transfers them to DAC registers on LDAC. Define DAC_RX_STATS_EN for event counters.
module dac_bus_receiver #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CLR_VALUE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] db,
  input  logic [1:0] A,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       ldac_n,
  input  logic       clr_n,
  input  logic       pd_n,
  output logic [7:0] dac_a,
  output logic [7:0] dac_b,
  output logic [7:0] dac_c,
  output logic [7:0] dac_d,
  output logic [7:0] in_a,
  output logic [7:0] in_b,
  output logic [7:0] in_c,
  output logic [7:0] in_d,
  output logic       wr_strobe,
  output logic [1:0] wr_addr,
  output logic       update_strobe,
  output logic       abort_strobe,
  output logic       powered_down
`ifdef DAC_RX_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] ldac_count,
  output logic [7:0]  abort_count
`endif
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  // Control bits packed as {pd_n, clr_n, ldac_n, wr_n, cs_n}
  logic [4:0] ctrl_sync_q [SYNC_STAGES];
  logic [9:0] data_sync_q [SYNC_STAGES];

  logic       cs_s, wr_s, ldac_s, clr_s, pd_s, clr_early_s, clear_s, flushed_s, ldac_edge_s;
  logic [7:0] db_s;
  logic [1:0] addr_s;

  state_t          state_q, state_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic [1:0]      hold_addr_q, hold_addr_d;
  logic [3:0][7:0] in_q, in_d_s, dac_q, dac_d_s;
  logic [1:0]      wr_addr_q, wr_addr_d;
  logic            wr_stb_q, wr_stb_d, upd_stb_q, upd_stb_d, abt_stb_q, abt_stb_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            ready_q, ready_d, ldac_prev_q, ldac_prev_d;

  // Input synchronizer chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ctrl_sync_q[i] <= 5'b11111;
        data_sync_q[i] <= 10'd0;
      end
    end else begin
      ctrl_sync_q[0] <= {pd_n, clr_n, ldac_n, wr_n, cs_n};
      data_sync_q[0] <= {A, db};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ctrl_sync_q[i] <= ctrl_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  assign {pd_s, clr_s, ldac_s, wr_s, cs_s} = ctrl_sync_q[SYNC_STAGES-1];
  assign {addr_s, db_s} = data_sync_q[SYNC_STAGES-1];
  // Clear taps one stage early so the registers reach CLR_VALUE SYNC_STAGES clk after the pin
  assign clr_early_s = ctrl_sync_q[SYNC_STAGES-2][3];
  assign clear_s     = ~clr_early_s | ~clr_s;
  // Until the chain has refilled after reset, its reset values must not look like bus events
  assign flushed_s   = (flush_cnt_q == 3'(SYNC_STAGES));
  assign ldac_edge_s = flushed_s & ldac_prev_q & ~ldac_s;

  // Bus FSM, clear/LDAC/commit priority and strobe generation
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    in_d_s      = in_q;
    dac_d_s     = dac_q;
    wr_addr_d   = wr_addr_q;
    wr_stb_d    = 1'b0;
    upd_stb_d   = 1'b0;
    abt_stb_d   = 1'b0;
    flush_cnt_d = flushed_s ? flush_cnt_q : flush_cnt_q + 3'd1;
    ready_d     = ready_q | (flushed_s & wr_s);
    ldac_prev_d = flushed_s ? ldac_s : 1'b0;
    if (clear_s) begin
      state_d = IDLE;
      in_d_s  = {4{CLR_VALUE}};
      dac_d_s = {4{CLR_VALUE}};
    end else begin
      if (ldac_edge_s) begin
        dac_d_s   = in_q;
        upd_stb_d = 1'b1;
      end else begin
        upd_stb_d = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (flushed_s && ready_q && !cs_s && !wr_s) begin
            state_d     = ARMED;
            hold_data_d = db_s;
            hold_addr_d = addr_s;
          end else begin
            state_d = IDLE;
          end
        end
        ARMED: begin
          if (cs_s) begin
            abt_stb_d = 1'b1;
            state_d   = IDLE;
          end else if (!wr_s) begin
            hold_data_d = db_s;
            hold_addr_d = addr_s;
          end else begin
            in_d_s[hold_addr_q] = hold_data_q;
            wr_addr_d           = hold_addr_q;
            wr_stb_d            = 1'b1;
            state_d             = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_data_q <= 8'd0;
      hold_addr_q <= 2'd0;
      in_q        <= {4{CLR_VALUE}};
      dac_q       <= {4{CLR_VALUE}};
      wr_addr_q   <= 2'd0;
      wr_stb_q    <= 1'b0;
      upd_stb_q   <= 1'b0;
      abt_stb_q   <= 1'b0;
      flush_cnt_q <= 3'd0;
      ready_q     <= 1'b0;
      ldac_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      in_q        <= in_d_s;
      dac_q       <= dac_d_s;
      wr_addr_q   <= wr_addr_d;
      wr_stb_q    <= wr_stb_d;
      upd_stb_q   <= upd_stb_d;
      abt_stb_q   <= abt_stb_d;
      flush_cnt_q <= flush_cnt_d;
      ready_q     <= ready_d;
      ldac_prev_q <= ldac_prev_d;
    end
  end

  assign {in_d, in_c, in_b, in_a}     = in_q;
  assign {dac_d, dac_c, dac_b, dac_a} = dac_q;
  assign wr_addr       = wr_addr_q;
  assign wr_strobe     = wr_stb_q;
  assign update_strobe = upd_stb_q;
  assign abort_strobe  = abt_stb_q;
  assign powered_down  = ~pd_s;

`ifdef DAC_RX_STATS_EN
  logic [15:0] wr_cnt_q, ldac_cnt_q;
  logic [7:0]  abt_cnt_q;

  // Event counters survive clear, only reset zeroes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q   <= 16'd0;
      ldac_cnt_q <= 16'd0;
      abt_cnt_q  <= 8'd0;
    end else begin
      wr_cnt_q   <= wr_cnt_q + {15'd0, wr_stb_q};
      ldac_cnt_q <= ldac_cnt_q + {15'd0, upd_stb_q};
      abt_cnt_q  <= abt_cnt_q + {7'd0, abt_stb_q};
    end
  end

  assign wr_count    = wr_cnt_q;
  assign ldac_count  = ldac_cnt_q;
  assign abort_count = abt_cnt_q;
`endif

endmodule

// File: tb/tb_dac_bus_receiver.sv
// Scoreboard bench for dac_bus_receiver: each bus event pushes the expected strobe and register
// snapshot with its due cycle; a negedge monitor pops and compares whenever a strobe appears.
module tb_dac_bus_receiver;
  localparam int         S    = 2;
  localparam logic [7:0] CLRV = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] db;
  logic [1:0] A;
  logic       cs_n, wr_n, ldac_n, clr_n, pd_n;
  logic [7:0] dac_a, dac_b, dac_c, dac_d, in_a, in_b, in_c, in_d;
  logic       wr_strobe, update_strobe, abort_strobe, powered_down;
  logic [1:0] wr_addr;
`ifdef DAC_RX_STATS_EN
  logic [15:0] wr_count, ldac_count;
  logic [7:0]  abort_count;
`endif

  dac_bus_receiver #(.SYNC_STAGES(S), .CLR_VALUE(CLRV)) dut (
    .clk(clk), .rst_n(rst_n), .db(db), .A(A), .cs_n(cs_n), .wr_n(wr_n),
    .ldac_n(ldac_n), .clr_n(clr_n), .pd_n(pd_n),
    .dac_a(dac_a), .dac_b(dac_b), .dac_c(dac_c), .dac_d(dac_d),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .update_strobe(update_strobe),
    .abort_strobe(abort_strobe), .powered_down(powered_down)
`ifdef DAC_RX_STATS_EN
    , .wr_count(wr_count), .ldac_count(ldac_count), .abort_count(abort_count)
`endif
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        w, u, a;
    logic [1:0]  addr;
    logic [31:0] in_v, dac_v;
    int          due;
  } rec_t;

  rec_t            exp_q[$];
  logic [3:0][7:0] in_m, dac_m;
  int              n_vec = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] in_all();
    return {in_d, in_c, in_b, in_a};
  endfunction

  function automatic logic [31:0] dac_all();
    return {dac_d, dac_c, dac_b, dac_a};
  endfunction

  task automatic push(input logic w, input logic u, input logic a, input logic [1:0] addr);
    rec_t r;
    r.w = w; r.u = u; r.a = a; r.addr = addr;
    r.in_v = in_m; r.dac_v = dac_m; r.due = cyc + S + 1;
    exp_q.push_back(r);
  endtask

  // Monitor: every strobe must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wr_strobe || update_strobe || abort_strobe)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, wr_strobe, update_strobe, abort_strobe}, 32'd0);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        check("strobes", {29'd0, wr_strobe, update_strobe, abort_strobe}, {29'd0, r.w, r.u, r.a});
        check("latency", cyc, r.due);
        check("in_regs", in_all(), r.in_v);
        check("dac_regs", dac_all(), r.dac_v);
        if (r.w) check("wr_addr", {30'd0, wr_addr}, {30'd0, r.addr});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick(1);
    check("drain", exp_q.size(), 32'd0);
    tick(2);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic with_ldac);
    A = a; db = d; cs_n = 1'b0; wr_n = 1'b0;
    tick(2);
    wr_n = 1'b1;
    if (with_ldac) begin
      ldac_n = 1'b0;
      dac_m = in_m;
    end
    in_m[a] = d;
    push(1'b1, with_ldac, 1'b0, a);
    tick(1);
    cs_n = 1'b1;
    tick(1);
    if (with_ldac) begin
      ldac_n = 1'b1;
      tick(2);
    end
  endtask

  task automatic pulse_ldac(input int low);
    ldac_n = 1'b0;
    dac_m = in_m;
    push(1'b0, 1'b1, 1'b0, 2'd0);
    tick(low);
    ldac_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; db = 8'h00; A = 2'd0; cs_n = 1'b1; wr_n = 1'b1;
    ldac_n = 1'b1; clr_n = 1'b1; pd_n = 1'b1;
    in_m = {4{CLRV}}; dac_m = {4{CLRV}};
    tick(3);
    check("rst_in", in_all(), {4{CLRV}});
    check("rst_dac", dac_all(), {4{CLRV}});
    check("rst_strobes_pd", {27'd0, wr_addr, wr_strobe, update_strobe, abort_strobe, powered_down}, 32'd0);
    rst_n = 1'b1;
    tick(S + 3);

    // Single write to channel C
    bus_write(2'd2, 8'h5A, 1'b0);
    drain();
    check("dac_c_untouched", {24'd0, dac_c}, {24'd0, CLRV});

    // Four back-to-back writes then one LDAC, held low long
    bus_write(2'd0, 8'h11, 1'b0);
    bus_write(2'd1, 8'h22, 1'b0);
    bus_write(2'd2, 8'h33, 1'b0);
    bus_write(2'd3, 8'h44, 1'b0);
    pulse_ldac(10);
    drain();
    check("dac_after_ldac", dac_all(), 32'h44332211);

    // Commit coinciding with LDAC edge
    bus_write(2'd0, 8'h10, 1'b0);
    drain();
    bus_write(2'd0, 8'hAA, 1'b1);
    drain();
    check("coinc_dac_a", {24'd0, dac_a}, 32'h10);
    check("coinc_in_a", {24'd0, in_a}, 32'hAA);

    // Abort by raising cs_n while wr_n is still low
    A = 2'd1; db = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    tick(2);
    cs_n = 1'b1;
    push(1'b0, 1'b0, 1'b1, 2'd0);
    tick(1);
    wr_n = 1'b1;
    drain();
    check("abort_in_b", {24'd0, in_b}, 32'h22);
`ifdef DAC_RX_STATS_EN
    check("abort_count", {24'd0, abort_count}, 32'd1);
`endif

    // Clear for 5 clk while toggling wr_n and ldac_n
    clr_n = 1'b0; cs_n = 1'b0; A = 2'd3; db = 8'hEE;
    in_m = {4{CLRV}}; dac_m = {4{CLRV}};
    for (int k = 0; k < 5; k++) begin
      wr_n = k[0];
      ldac_n = k[0];
      tick(1);
      if (k == S - 1) begin
        check("clr_in", in_all(), {4{CLRV}});
        check("clr_dac", dac_all(), {4{CLRV}});
      end
    end
    clr_n = 1'b1; wr_n = 1'b1; ldac_n = 1'b1; cs_n = 1'b1;
    tick(S + 4);
    check("clr_hold_in", in_all(), {4{CLRV}});

    // Reset dropped mid-write
    bus_write(2'd1, 8'h3C, 1'b0);
    drain();
    A = 2'd3; db = 8'h99; cs_n = 1'b0; wr_n = 1'b0;
    tick(2);
    rst_n = 1'b0;
    in_m = {4{CLRV}};
    tick(1);
    check("midrst_in", in_all(), {4{CLRV}});
    rst_n = 1'b1;
    tick(S + 3);
    wr_n = 1'b1;
    tick(S + 3);
    cs_n = 1'b1;
    tick(2);
    check("midrst_no_commit", in_all(), {4{CLRV}});
    check("midrst_wr_addr", {30'd0, wr_addr}, 32'd0);

    // Power-down latency and writes while powered down
    pd_n = 1'b0;
    tick(S - 1);
    check("pd_early", {31'd0, powered_down}, 32'd0);
    tick(1);
    check("pd_on", {31'd0, powered_down}, 32'd1);
    bus_write(2'd1, 8'hC3, 1'b0);
    drain();
    check("pd_in_b", {24'd0, in_b}, 32'hC3);
    pd_n = 1'b1;
    tick(S);
    check("pd_off", {31'd0, powered_down}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dac_bus_receiver.md
# dac_bus_receiver

Receiving end of the quad 8-bit parallel DAC write bus (db, A, wr_n, cs_n, ldac_n, clr_n, pd_n) driven by the pattern generator's DAC controller. It synchronizes the asynchronous bus into the local clock and decodes write cycles into four input registers. On LDAC it transfers those registers to four DAC registers, and it honours clear and power-down. It serves as a loopback/readback monitor for hardware checks and as the DAC model in pattern-generator benches.

## Interface
- SYNC_STAGES, 2, synchronizer depth on every bus input (legal 2..4)
- CLR_VALUE, 8'h00, value loaded into all input/DAC registers on reset and on clear
- clk  in  1  system clock (125 MHz)
- rst_n  in  1  reset, asynchronous assert, active-low
- db  in  8  bus data
- A  in  2  channel address (0=A, 1=B, 2=C, 3=D)
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low, commit on rising edge
- ldac_n  in  1  load-DAC, active-low, transfer on falling edge
- clr_n  in  1  clear, active-low, level
- pd_n  in  1  power-down, active-low, level
- dac_a, dac_b, dac_c, dac_d  out  8 each  DAC (output) registers
- in_a, in_b, in_c, in_d  out  8 each  input registers
- wr_strobe  out  1  one-cycle pulse per committed write
- wr_addr  out  2  address of last committed write
- update_strobe  out  1  one-cycle pulse per LDAC transfer
- abort_strobe  out  1  one-cycle pulse when a write is aborted by cs_n deassert
- powered_down  out  1  synchronized inverse of pd_n

## Operation
- All seven inputs pass through SYNC_STAGES flops. On reset, control stages load 1 (inactive) and data/address stages load 0.
- Bus FSM, two states:
  - IDLE -> ARMED when sync cs_n=0 and wr_n=0. The db/A sampled in that cycle are held.
  - ARMED: each cycle with wr_n=0 and cs_n=0, refresh held db/A.
  - ARMED, wr_n=1 and cs_n=0 -> commit held db/A into in_x, pulse wr_strobe, update wr_addr, -> IDLE. The committed data is the value sampled while wr_n was still low.
  - ARMED, cs_n=1 (any wr_n) -> abort, no register change, pulse abort_strobe, -> IDLE.
- LDAC: a sync ldac_n 1->0 edge copies in_a..in_d into dac_a..dac_d simultaneously and pulses update_strobe. ldac_n held low does not re-transfer.
- Clear: while sync clr_n=0, all in_x and dac_x are held at CLR_VALUE and the FSM is forced to IDLE. Commits and LDAC edges are ignored, and no strobes are generated.
- Priority in one cycle: clear > LDAC > commit. A commit coinciding with an LDAC edge lands in in_x only; dac_x receives the pre-commit in_x values.
- Power-down: powered_down = ~sync pd_n. Registers are retained and writes and LDAC still operate.

## Timing
- Reset values:
  - dac_x and in_x = CLR_VALUE.
  - wr_addr = 0.
  - All strobes = 0.
  - powered_down = 0.
  - FSM = IDLE.
- Commit latency: SYNC_STAGES+1 clk from the wr_n rising edge at the pin to the in_x update and wr_strobe.
- LDAC latency: SYNC_STAGES+1 clk from the ldac_n falling edge to the dac_x update and update_strobe.
- Clear and powered_down latency: SYNC_STAGES clk.
- Required bus timing:
  - wr_n low and high phases each >= 2 clk.
  - db/A stable from wr_n fall to >= 1 clk after wr_n rise.
  - Narrower pulses may be missed and must not corrupt other channels.
- Consecutive writes at the minimum spacing all commit.
- A rising edge of rst_n mid-write drops the write. The FSM restarts in IDLE and needs a fresh wr_n low phase.

## Configuration
- DAC_RX_STATS_EN defined: adds outputs wr_count[15:0], ldac_count[15:0] and abort_count[7:0]. They increment on wr_strobe, update_strobe and abort_strobe respectively, wrap modulo 2^N, reset to 0 on rst_n, and are not cleared by clr_n.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then write A=2 db=8'h5A -> in_c=8'h5A after SYNC_STAGES+1 clk, wr_strobe 1 cycle, wr_addr=2, dac_c still 8'h00.
- Write A..D = 8'h11, 8'h22, 8'h33, 8'h44, then pulse ldac_n low -> dac_a..d = 8'h11/22/33/44, one update_strobe. Holding ldac_n low 10 clk gives no further strobe.
- Commit A=0 db=8'hAA in the same cycle as an LDAC edge, with in_a previously 8'h10 -> dac_a=8'h10, in_a=8'hAA.
- Start a write (wr_n low), raise cs_n before wr_n -> abort_strobe, in_x unchanged. With DAC_RX_STATS_EN, abort_count=1.
- Load nonzero values, assert clr_n low for 5 clk while toggling wr_n and ldac_n -> all registers CLR_VALUE, no wr_strobe/update_strobe.
- Assert rst_n low with wr_n low mid-write, release, raise wr_n -> no commit. pd_n=0 -> powered_down=1 after SYNC_STAGES clk, and writes still commit.
